// File: rtl/pkt_gen_pkg.sv
// Shared definitions for the AXIS packet generator: register map, FSM states
// and register reset values.
package pkt_gen_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_LEN    = 8'h01;
    localparam logic [7:0] ADDR_COUNT  = 8'h02;
    localparam logic [7:0] ADDR_GAP    = 8'h03;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_SENT   = 8'h05;

    localparam logic [7:0] LEN_RST   = 8'd4;
    localparam logic [7:0] COUNT_RST = 8'd1;
    localparam logic [7:0] GAP_RST   = 8'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // LEN of 0 encodes 256 words; the 8-bit wrap of len-1 yields 255.
    function automatic logic is_last_word(input logic [7:0] idx, input logic [7:0] len);
        return idx == (len - 8'd1);
    endfunction

endpackage

// File: rtl/pkt_gen.sv
// AXIS packet generator with 8-bit Avalon-MM control slave.
// Optional run-complete interrupt enable is built when PKT_GEN_IRQ_EN is defined.
module pkt_gen
    import pkt_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  writedata,
    input  logic        write,
    input  logic        chipselect,
    input  logic [7:0]  address,
    input  logic        read,
    output logic [7:0]  readdata,
    output logic [15:0] tx_tdata,
    output logic        tx_tvalid,
    input  logic        tx_tready,
    output logic        tx_tlast,
    output logic        irq
);

    state_t      state_r, state_nx_s;
    logic [7:0]  len_r, count_r, gap_r;
    logic [7:0]  len_sh_r, count_sh_r, gap_sh_r;
    logic [7:0]  sent_r, gap_cnt_r, first_pkt_s, rd_mux_s;
    logic        done_r, done_nx_s, abort_pend_r;
    logic        tx_tvalid_r, tx_tlast_r, irq_en_s;
    logic [15:0] tx_tdata_r;
    logic [7:0]  readdata_r;
    logic        load_first_s, load_next_s, clr_valid_s, done_set_s, gap_load_s;

    wire         wr_s        = chipselect & write;
    wire         rd_s        = chipselect & read;
    wire         ctrl_wr_s   = wr_s & (address == ADDR_CTRL);
    wire         start_s     = ctrl_wr_s & writedata[0] & ~writedata[1];
    wire         abort_s     = ctrl_wr_s & writedata[1];
    wire         run_start_s = start_s & (state_r == IDLE);
    wire         hs_s        = tx_tvalid_r & tx_tready;
    wire         last_hs_s   = hs_s & tx_tlast_r;
    wire [7:0]   sent_inc_s  = sent_r + 8'd1;
    wire [7:0]   word_inc_s  = tx_tdata_r[7:0] + 8'd1;
    wire         final_s     = (sent_inc_s == count_sh_r) | abort_pend_r | abort_s;

    // Next-state and datapath control decisions.
    always_comb begin
        state_nx_s   = state_r;
        load_first_s = 1'b0;
        load_next_s  = 1'b0;
        clr_valid_s  = 1'b0;
        done_set_s   = 1'b0;
        gap_load_s   = 1'b0;
        first_pkt_s  = sent_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    if (count_r != 8'd0) begin
                        state_nx_s = SEND;
                    end else begin
                        done_set_s = 1'b1;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SEND: begin
                if (!tx_tvalid_r) begin
                    load_first_s = 1'b1;
                end else if (last_hs_s) begin
                    if (final_s) begin
                        state_nx_s  = IDLE;
                        clr_valid_s = 1'b1;
                        done_set_s  = 1'b1;
                    end else if (gap_sh_r != 8'd0) begin
                        state_nx_s  = GAP;
                        clr_valid_s = 1'b1;
                        gap_load_s  = 1'b1;
                    end else begin
                        load_first_s = 1'b1;
                        first_pkt_s  = sent_inc_s;
                    end
                end else if (hs_s) begin
                    load_next_s = 1'b1;
                end else begin
                    state_nx_s = SEND;
                end
            end
            GAP: begin
                if (abort_pend_r || abort_s) begin
                    state_nx_s = IDLE;
                    done_set_s = 1'b1;
                end else if (gap_cnt_r == 8'd1) begin
                    state_nx_s   = SEND;
                    load_first_s = 1'b1;
                end else begin
                    state_nx_s = GAP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Sticky done: completion wins over a same-cycle clear.
    always_comb begin
        if (done_set_s) begin
            done_nx_s = 1'b1;
        end else if (run_start_s || (wr_s && (address == ADDR_STATUS))) begin
            done_nx_s = 1'b0;
        end else begin
            done_nx_s = done_r;
        end
    end

`ifdef PKT_GEN_IRQ_EN
    logic irq_en_r, irq_en_nx_s, irq_r;

    // Interrupt enable lives in CTRL bit2 and is rewritten by every CTRL write.
    always_comb begin
        if (ctrl_wr_s) begin
            irq_en_nx_s = writedata[2];
        end else begin
            irq_en_nx_s = irq_en_r;
        end
    end

    // Enable register and registered level interrupt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            irq_en_r <= irq_en_nx_s;
            irq_r    <= done_nx_s & irq_en_nx_s;
        end
    end

    assign irq_en_s = irq_en_r;
    assign irq      = irq_r;
`else
    assign irq_en_s = 1'b0;
    assign irq      = 1'b0;
`endif

    // Register read multiplexer.
    always_comb begin
        case (address)
            ADDR_CTRL:   rd_mux_s = {5'd0, irq_en_s, 2'd0};
            ADDR_LEN:    rd_mux_s = len_r;
            ADDR_COUNT:  rd_mux_s = count_r;
            ADDR_GAP:    rd_mux_s = gap_r;
            ADDR_STATUS: rd_mux_s = {6'd0, done_r, (state_r != IDLE)};
            ADDR_SENT:   rd_mux_s = sent_r;
            default:     rd_mux_s = 8'd0;
        endcase
    end

    // Software-visible configuration registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_r   <= LEN_RST;
            count_r <= COUNT_RST;
            gap_r   <= GAP_RST;
        end else if (wr_s) begin
            case (address)
                ADDR_LEN:   len_r   <= writedata;
                ADDR_COUNT: count_r <= writedata;
                ADDR_GAP:   gap_r   <= writedata;
                default:    ;
            endcase
        end
    end

    // Run control: state, shadow copies taken at START, progress counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            len_sh_r     <= LEN_RST;
            count_sh_r   <= COUNT_RST;
            gap_sh_r     <= GAP_RST;
            sent_r       <= 8'd0;
            done_r       <= 1'b0;
            abort_pend_r <= 1'b0;
            gap_cnt_r    <= 8'd0;
        end else begin
            state_r <= state_nx_s;
            done_r  <= done_nx_s;
            if (run_start_s) begin
                len_sh_r   <= len_r;
                count_sh_r <= count_r;
                gap_sh_r   <= gap_r;
                sent_r     <= 8'd0;
            end else if (last_hs_s) begin
                sent_r <= sent_inc_s;
            end
            if (state_nx_s == IDLE) begin
                abort_pend_r <= 1'b0;
            end else if (abort_s) begin
                abort_pend_r <= 1'b1;
            end
            if (gap_load_s) begin
                gap_cnt_r <= gap_sh_r;
            end else if (state_r == GAP) begin
                gap_cnt_r <= gap_cnt_r - 8'd1;
            end
        end
    end

    // AXIS output register; only advances when empty or on a handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_tvalid_r <= 1'b0;
            tx_tlast_r  <= 1'b0;
            tx_tdata_r  <= 16'd0;
        end else if (load_first_s) begin
            tx_tvalid_r <= 1'b1;
            tx_tlast_r  <= is_last_word(8'd0, len_sh_r);
            tx_tdata_r  <= {first_pkt_s, 8'd0};
        end else if (load_next_s) begin
            tx_tlast_r  <= is_last_word(word_inc_s, len_sh_r);
            tx_tdata_r  <= {tx_tdata_r[15:8], word_inc_s};
        end else if (clr_valid_s) begin
            tx_tvalid_r <= 1'b0;
            tx_tlast_r  <= 1'b0;
        end
    end

    // Read data is registered one cycle after the strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata_r <= 8'd0;
        end else if (rd_s) begin
            readdata_r <= rd_mux_s;
        end
    end

    assign tx_tvalid = tx_tvalid_r;
    assign tx_tlast  = tx_tlast_r;
    assign tx_tdata  = tx_tdata_r;
    assign readdata  = readdata_r;

endmodule

// File: tb/tb_pkt_gen.sv
// Self-checking bench for pkt_gen: scoreboard of expected AXIS words,
// register readback and timing checks. Honors PKT_GEN_IRQ_EN.
module tb_pkt_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  writedata = 8'd0;
    logic        write = 1'b0;
    logic        chipselect = 1'b0;
    logic [7:0]  address = 8'd0;
    logic        read = 1'b0;
    logic [7:0]  readdata;
    logic [15:0] tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready = 1'b1;
    logic        tx_tlast;
    logic        irq;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [16:0] exp_q[$];
    int          hs_cyc_q[$];
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic        prev_l = 1'b0;
    logic [15:0] prev_d = 16'd0;

    pkt_gen dut (
        .clk(clk), .reset(reset), .writedata(writedata), .write(write),
        .chipselect(chipselect), .address(address), .read(read),
        .readdata(readdata), .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid),
        .tx_tready(tx_tready), .tx_tlast(tx_tlast), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: held-word stability and scoreboard pop on each handshake.
    always @(negedge clk) begin
        logic [16:0] e;
        if (reset) begin
            if (prev_v && !prev_r) begin
                n_cmp++;
                if ({tx_tvalid, tx_tlast, tx_tdata} !== {1'b1, prev_l, prev_d}) begin
                    n_bad++;
                    $display("FAIL hold_stable: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                             tx_tvalid, tx_tlast, tx_tdata, prev_l, prev_d);
                end
            end
            if (tx_tvalid && tx_tready) begin
                hs_cyc_q.push_back(cyc);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_word: got l=%b d=%h want none", tx_tlast, tx_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({tx_tlast, tx_tdata} !== e) begin
                        n_bad++;
                        $display("FAIL tx_word: got l=%b d=%h want l=%b d=%h",
                                 tx_tlast, tx_tdata, e[16], e[15:0]);
                    end
                end
            end
            prev_v = tx_tvalid;
            prev_r = tx_tready;
            prev_l = tx_tlast;
            prev_d = tx_tdata;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
        @(posedge clk); #1;
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic push_pkt(input int pkt, input int len);
        logic [7:0] pb;
        logic [7:0] wb;
        pb = 8'(pkt);
        for (int w = 0; w < len; w++) begin
            wb = 8'(w);
            exp_q.push_back({(w == len - 1), pb, wb});
        end
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || tx_tvalid) && i < budget) begin
            @(posedge clk);
            i++;
        end
        n_cmp++;
        if (i >= budget) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d words left want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        logic [7:0] addrs[6];
        logic [7:0] want[6];
        addrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        want  = '{8'h00, 8'h04, 8'h01, 8'h00, 8'h00, 8'h00};
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({tx_tvalid, tx_tlast, tx_tdata, readdata, irq} !== 27'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b l=%b d=%h rd=%h irq=%b want all 0",
                     tx_tvalid, tx_tlast, tx_tdata, readdata, irq);
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus_rd(addrs[i], v);
            n_cmp++;
            if (v !== want[i]) begin
                n_bad++;
                $display("FAIL reset_reg%0d: got %h want %h", i, v, want[i]);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] v;
        bus_wr(8'h01, 8'd4);
        bus_wr(8'h02, 8'd1);
        bus_wr(8'h03, 8'd0);
        hs_cyc_q.delete();
        push_pkt(0, 4);
        bus_wr(8'h00, 8'h01);
        n_cmp++;
        if (tx_tvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL start_latency_early: got tvalid=%b want 0", tx_tvalid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({tx_tvalid, tx_tdata} !== {1'b1, 16'h0000}) begin
            n_bad++;
            $display("FAIL start_latency: got v=%b d=%h want v=1 d=0000", tx_tvalid, tx_tdata);
        end
        wait_drain(100);
        bus_rd(8'h04, v);
        n_cmp++;
        if (v !== 8'h02) begin n_bad++; $display("FAIL single_status: got %h want 02", v); end
        bus_rd(8'h05, v);
        n_cmp++;
        if (v !== 8'h01) begin n_bad++; $display("FAIL single_sent: got %h want 01", v); end
    endtask

    task automatic test_gap();
        logic [7:0] v;
        bus_wr(8'h01, 8'd2);
        bus_wr(8'h02, 8'd3);
        bus_wr(8'h03, 8'd2);
        hs_cyc_q.delete();
        for (int p = 0; p < 3; p++) push_pkt(p, 2);
        bus_wr(8'h00, 8'h01);
        bus_wr(8'h00, 8'h01);
        wait_drain(200);
        n_cmp++;
        if (hs_cyc_q.size() != 6) begin
            n_bad++;
            $display("FAIL gap_words: got %0d want 6", hs_cyc_q.size());
        end else begin
            if ((hs_cyc_q[1] - hs_cyc_q[0]) != 1 || (hs_cyc_q[2] - hs_cyc_q[1]) != 3 ||
                (hs_cyc_q[4] - hs_cyc_q[3]) != 3) begin
                n_bad++;
                $display("FAIL gap_spacing: got %0d,%0d,%0d want 1,3,3",
                         hs_cyc_q[1] - hs_cyc_q[0], hs_cyc_q[2] - hs_cyc_q[1],
                         hs_cyc_q[4] - hs_cyc_q[3]);
            end
        end
        bus_rd(8'h05, v);
        n_cmp++;
        if (v !== 8'h03) begin n_bad++; $display("FAIL gap_sent: got %h want 03", v); end
    endtask

    task automatic test_back_to_back();
        int gaps;
        bus_wr(8'h01, 8'd2);
        bus_wr(8'h02, 8'd3);
        bus_wr(8'h03, 8'd0);
        hs_cyc_q.delete();
        for (int p = 0; p < 3; p++) push_pkt(p, 2);
        bus_wr(8'h00, 8'h01);
        wait_drain(200);
        gaps = 0;
        for (int i = 1; i < hs_cyc_q.size(); i++)
            if (hs_cyc_q[i] - hs_cyc_q[i-1] != 1) gaps++;
        n_cmp++;
        if (hs_cyc_q.size() != 6 || gaps != 0) begin
            n_bad++;
            $display("FAIL b2b_throughput: got %0d words %0d bubbles want 6 words 0 bubbles",
                     hs_cyc_q.size(), gaps);
        end
    endtask

    task automatic test_len256();
        logic [7:0] v;
        bus_wr(8'h01, 8'd0);
        bus_wr(8'h02, 8'd1);
        hs_cyc_q.delete();
        push_pkt(0, 256);
        bus_wr(8'h00, 8'h01);
        wait_drain(1000);
        n_cmp++;
        if (hs_cyc_q.size() != 256) begin
            n_bad++;
            $display("FAIL len256_words: got %0d want 256", hs_cyc_q.size());
        end
        bus_rd(8'h05, v);
        n_cmp++;
        if (v !== 8'h01) begin n_bad++; $display("FAIL len256_sent: got %h want 01", v); end
    endtask

    task automatic test_backpressure();
        int i;
        bus_wr(8'h01, 8'd3);
        bus_wr(8'h02, 8'd1);
        hs_cyc_q.delete();
        push_pkt(0, 3);
        bus_wr(8'h00, 8'h01);
        i = 0;
        while ((exp_q.size() != 0 || tx_tvalid) && i < 100) begin
            @(posedge clk); #1;
            tx_tready = ~tx_tready;
            i++;
        end
        tx_tready = 1'b1;
        wait_drain(50);
        n_cmp++;
        if (hs_cyc_q.size() != 3) begin
            n_bad++;
            $display("FAIL bp_words: got %0d want 3", hs_cyc_q.size());
        end
    endtask

    task automatic test_abort();
        logic [7:0] v;
        int i;
        bus_wr(8'h01, 8'd8);
        bus_wr(8'h02, 8'd10);
        bus_wr(8'h03, 8'd0);
        hs_cyc_q.delete();
        push_pkt(0, 8);
        bus_wr(8'h00, 8'h01);
        i = 0;
        while (hs_cyc_q.size() < 4 && i < 50) begin
            @(posedge clk);
            i++;
        end
        bus_wr(8'h00, 8'h02);
        wait_drain(100);
        bus_rd(8'h04, v);
        n_cmp++;
        if (v !== 8'h02) begin n_bad++; $display("FAIL abort_status: got %h want 02", v); end
        bus_rd(8'h05, v);
        n_cmp++;
        if (v !== 8'h01) begin n_bad++; $display("FAIL abort_sent: got %h want 01", v); end
        // START together with ABORT must not launch a run.
        bus_wr(8'h00, 8'h03);
        repeat (4) @(posedge clk);
        #1;
        bus_rd(8'h04, v);
        n_cmp++;
        if (v !== 8'h02) begin n_bad++; $display("FAIL start_abort_status: got %h want 02", v); end
    endtask

    task automatic test_count_zero();
        logic [7:0] v;
        logic       seen_v;
        bus_wr(8'h02, 8'd0);
        bus_wr(8'h04, 8'h00);
        hs_cyc_q.delete();
        bus_wr(8'h00, 8'h05);
        bus_rd(8'h04, v);
        n_cmp++;
        if (v !== 8'h02) begin n_bad++; $display("FAIL zero_status: got %h want 02", v); end
        seen_v = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen_v = seen_v | tx_tvalid;
        end
        n_cmp++;
        if (seen_v !== 1'b0) begin n_bad++; $display("FAIL zero_tvalid: got 1 want 0"); end
        bus_rd(8'h00, v);
`ifdef PKT_GEN_IRQ_EN
        n_cmp++;
        if (v !== 8'h04) begin n_bad++; $display("FAIL ctrl_read: got %h want 04", v); end
        n_cmp++;
        if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_set: got %b want 1", irq); end
`else
        n_cmp++;
        if (v !== 8'h00) begin n_bad++; $display("FAIL ctrl_read: got %h want 00", v); end
        n_cmp++;
        if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_tied: got %b want 0", irq); end
`endif
        bus_wr(8'h04, 8'h00);
        n_cmp++;
        if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear: got %b want 0", irq); end
        bus_rd(8'h04, v);
        n_cmp++;
        if (v !== 8'h00) begin n_bad++; $display("FAIL done_clear: got %h want 00", v); end
        bus_wr(8'h00, 8'h00);
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        logic [7:0] addrs[5];
        logic [7:0] want[5];
        int i;
        addrs = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        want  = '{8'h04, 8'h01, 8'h00, 8'h00, 8'h00};
        bus_wr(8'h01, 8'd8);
        bus_wr(8'h02, 8'd5);
        bus_wr(8'h03, 8'd1);
        hs_cyc_q.delete();
        for (int p = 0; p < 5; p++) push_pkt(p, 8);
        bus_wr(8'h00, 8'h01);
        i = 0;
        while (hs_cyc_q.size() < 3 && i < 50) begin
            @(posedge clk);
            i++;
        end
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        n_cmp++;
        if ({tx_tvalid, tx_tlast, tx_tdata} !== 18'd0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got v=%b l=%b d=%h want 0", tx_tvalid, tx_tlast, tx_tdata);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus_rd(addrs[k], v);
            n_cmp++;
            if (v !== want[k]) begin
                n_bad++;
                $display("FAIL reset_mid_reg%0d: got %h want %h", k, v, want[k]);
            end
        end
        n_cmp++;
        if (tx_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_mid_idle: got tvalid=1 want 0"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap();
        test_back_to_back();
        test_len256();
        test_backpressure();
        test_abort();
        test_count_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pkt_gen.md
# pkt_gen

AXIS packet generator: the transmit-side counterpart to the ingress filter ports, producing deterministic 16-bit packets with tlast framing for one ingress port. Software configures packet length, packet count and inter-packet gap over the same 8-bit Avalon-MM slave style as the filter, then starts a run. Used as on-chip traffic source for bring-up and for filter self-test.

## Interface
- No parameters.
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- writedata  in  8  Avalon write data.
- write  in  1  Avalon write strobe.
- chipselect  in  1  Avalon select.
- address  in  8  register byte address.
- read  in  1  Avalon read strobe.
- readdata  out  8  registered read data.
- tx_tdata  out  16  AXIS data.
- tx_tvalid  out  1  AXIS valid.
- tx_tready  in  1  AXIS ready.
- tx_tlast  out  1  last word of packet.
- irq  out  1  run-complete interrupt (level).

## Operation
- Registers (writes need chipselect&&write; reads need chipselect&&read):
  - 0x0 CTRL W: bit0 START (pulse, not stored), bit1 ABORT (pulse). Read returns 0.
  - 0x1 LEN RW: words per packet; 0 means 256. Reset 8'd4.
  - 0x2 COUNT RW: packets per run; 0 means run does nothing (immediate done). Reset 8'd1.
  - 0x3 GAP RW: idle cycles between packets. Reset 0.
  - 0x4 STATUS R: bit0 busy, bit1 done (sticky), bits7:2 0. Any write to 0x4 clears done.
  - 0x5 SENT R: packets completed in current/last run, wraps at 256.
  - Unmapped: reads return 0, writes ignored.
- START while idle latches LEN/COUNT/GAP into shadow registers, clears SENT and done; START while busy ignored. Register writes during a run affect only the next run.
- FSM: IDLE -> SEND (START, COUNT!=0) | IDLE with done=1 (START, COUNT==0); SEND -> GAP (tlast handshake, more packets, GAP!=0) | SEND (same, GAP==0) | IDLE done=1 (tlast handshake on final packet or abort pending); GAP -> SEND when gap counter expires, or IDLE done=1 if abort pending.
- Data word: tdata = {pkt_idx[7:0], word_idx[7:0]}; pkt_idx = SENT value at packet start, word_idx 0..LEN-1 (LEN=256 wraps word_idx to 255 on last word).
- tlast high exactly on word_idx == LEN-1.
- ABORT never truncates a packet: current packet completes, then IDLE; ABORT in IDLE ignored.
- Simultaneous START and ABORT in one write: ABORT wins, START ignored.

## Timing
- Outputs reset: tx_tvalid=0, tx_tlast=0, tx_tdata=0, readdata=0, irq=0; all registers to stated values.
- readdata valid one cycle after the read strobe.
- START write sampled at edge k; tx_tvalid=1 with word 0 after edge k+1.
- tvalid/tdata/tlast registered; once tvalid=1 they hold stable until tready=1 at a rising edge.
- Full throughput: one word per cycle while tready=1; GAP=0 gives back-to-back packets.
- GAP=g: after the tlast handshake edge, tvalid low for exactly g cycles.
- Reset assertion mid-packet: tvalid drops asynchronously, run discarded.

## Configuration
- PKT_GEN_IRQ_EN defined: irq = done & IRQ-enable, enable is CTRL bit2 stored (reset 0, readable at 0x0 bit2); clearing done deasserts irq next cycle.
- Undefined: irq tied 0, CTRL bit2 ignored and reads 0.

## Structure
- Shared package pkt_gen_pkg: register address constants, state enum (IDLE, SEND, GAP), reset values.
- Single module; no sub-module warranted.

## Test plan
- LEN=4, COUNT=1, tready=1, START -> words 0x0000,0x0001,0x0002,0x0003, tlast on 0x0003, STATUS=0x02, SENT=1.
- LEN=2, COUNT=3, GAP=2 -> 0x0000,0x0001,(2 idle),0x0100,0x0101,(2 idle),0x0200,0x0201; SENT=3.
- LEN=3, tready toggling 1/0 -> each word held stable while tready=0, sequence 0x0000..0x0002 unchanged.
- LEN=8, COUNT=10, ABORT after word 3 -> packet 0 finishes through 0x0007 with tlast, then idle, SENT=1, done=1.
- COUNT=0 START -> no tvalid, done=1 one cycle later; with PKT_GEN_IRQ_EN and enable set irq=1, write 0x4 -> irq=0.
- Reset low mid-packet -> tvalid=0 immediately, all registers at reset values.
